// File: rtl/spi_pkg.sv
// Shared SPI definitions: default frame width and the slave FSM state encoding.
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_WAIT_SS = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, with rise/fall detection
// taken from one extra registered copy of the synchronized level.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stage_reg;
    logic                   prev_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) stage_reg[gi] <= RESET_VAL;
                    else     stage_reg[gi] <= din;
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) stage_reg[gi] <= RESET_VAL;
                    else     stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_reg <= RESET_VAL;
        else     prev_reg <= stage_reg[SYNC_STAGES-1];
    end

    assign sync = stage_reg[SYNC_STAGES-1];
    assign rise = sync & ~prev_reg;
    assign fall = ~sync & prev_reg;

endmodule

// File: rtl/spi_slave.sv
// Oversampling SPI slave (CPOL=0): one MSB-first frame per ss assertion,
// one-entry transmit buffer, received words presented as a valid pulse.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  tx_underrun
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic sclk_sync, sclk_fall;
    logic ss_sync, ss_rise, ss_fall;
    logic mosi_sync;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst(rst), .din(sclk), .sync(sclk_sync), .rise(), .fall(sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst(rst), .din(ss), .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .din(mosi), .sync(mosi_sync), .rise(), .fall()
    );

    spi_state_e            state_reg;
    logic [DATA_WIDTH-1:0] tx_buf_reg;
    logic                  tx_full_reg;
    logic [DATA_WIDTH-1:0] tx_shift_reg;
    logic [DATA_WIDTH-1:0] rx_shift_reg;
    logic [CW-1:0]         bit_cnt_reg;
    logic                  miso_reg;
    logic [DATA_WIDTH-1:0] rx_data_reg;
    logic                  rx_valid_reg;
    logic                  frame_err_reg;
    logic                  tx_underrun_reg;

    logic                  frame_start;
    logic                  shift_edge;
    logic [DATA_WIDTH-1:0] load_word;
    logic [DATA_WIDTH-1:0] rx_next;
    logic [CW-1:0]         cnt_next;

    // sclk activity only counts while the slave is selected
    assign shift_edge  = sclk_fall & ~ss_sync;
    assign frame_start = (state_reg == ST_IDLE) && ss_fall;
    assign load_word   = tx_full_reg ? tx_buf_reg : '0;
    assign rx_next     = {rx_shift_reg[DATA_WIDTH-2:0], mosi_sync};
    assign cnt_next    = bit_cnt_reg + 1'b1;

    // Frame start reads the old buffer state, so a same-cycle write is kept
    // for the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_buf_reg  <= '0;
            tx_full_reg <= 1'b0;
        end else begin
            if (frame_start)
                tx_full_reg <= 1'b0;
            if (tx_valid && !tx_full_reg) begin
                tx_buf_reg  <= tx_data;
                tx_full_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            tx_shift_reg    <= '0;
            rx_shift_reg    <= '0;
            bit_cnt_reg     <= '0;
            miso_reg        <= 1'b0;
            rx_data_reg     <= '0;
            rx_valid_reg    <= 1'b0;
            frame_err_reg   <= 1'b0;
            tx_underrun_reg <= 1'b0;
        end else begin
            rx_valid_reg    <= 1'b0;
            frame_err_reg   <= 1'b0;
            tx_underrun_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    miso_reg <= 1'b0;
                    if (ss_fall) begin
                        state_reg       <= ST_SHIFT;
                        bit_cnt_reg     <= '0;
                        tx_shift_reg    <= load_word;
                        miso_reg        <= load_word[DATA_WIDTH-1];
                        tx_underrun_reg <= ~tx_full_reg;
                    end
                end
                ST_SHIFT: begin
                    if (ss_rise) begin
                        state_reg     <= ST_IDLE;
                        miso_reg      <= 1'b0;
                        frame_err_reg <= 1'b1;
                    end else if (shift_edge) begin
                        rx_shift_reg <= rx_next;
                        bit_cnt_reg  <= cnt_next;
                        tx_shift_reg <= {tx_shift_reg[DATA_WIDTH-2:0], 1'b0};
                        if (cnt_next == CW'(DATA_WIDTH)) begin
                            rx_data_reg  <= rx_next;
                            rx_valid_reg <= 1'b1;
                            miso_reg     <= 1'b0;
                            state_reg    <= ST_WAIT_SS;
                        end else begin
                            miso_reg <= tx_shift_reg[DATA_WIDTH-2];
                        end
                    end
                end
                ST_WAIT_SS: begin
                    miso_reg <= 1'b0;
                    if (ss_rise)
                        state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign miso        = miso_reg;
    assign tx_ready    = ~tx_full_reg;
    assign rx_data     = rx_data_reg;
    assign rx_valid    = rx_valid_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign frame_err   = frame_err_reg;
    assign tx_underrun = tx_underrun_reg;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a bit-banged SPI master drives frames, a
// monitor pops expected words on rx_valid and tallies the status pulses.
module tb_spi_slave;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          sclk, ss, mosi, miso;
    logic [DW-1:0] tx_data;
    logic          tx_valid, tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid, busy, frame_err, tx_underrun;

    spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .frame_err(frame_err), .tx_underrun(tx_underrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: buffer contents plus expected event counts
    logic [DW-1:0] rx_exp_q[$];
    bit            buf_full = 1'b0;
    logic [DW-1:0] buf_word = '0;
    logic [DW-1:0] last_rx  = '0;
    int exp_rx = 0, exp_err = 0, exp_udr = 0;
    int mon_rx = 0, mon_err = 0, mon_udr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (rx_valid === 1'b1) begin
                mon_rx++;
                if (rx_exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rx_unexpected: got rx_valid with data %0h, expected none", rx_data);
                end else begin
                    check("rx_data", {16'h0, rx_data}, {16'h0, rx_exp_q.pop_front()});
                end
            end
            if (frame_err === 1'b1)   mon_err++;
            if (tx_underrun === 1'b1) mon_udr++;
        end
    end

    task automatic tb_write(input logic [DW-1:0] w);
        check("tx_ready_pre", {31'h0, tx_ready}, {31'h0, !buf_full});
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 16'($urandom);
        if (!buf_full) begin
            buf_full = 1'b1;
            buf_word = w;
        end
        check("tx_ready_post", {31'h0, tx_ready}, 32'h0);
    endtask

    task automatic start_frame(output logic [DW-1:0] exp_miso);
        check("miso_idle", {31'h0, miso}, 32'h0);
        exp_miso = buf_full ? buf_word : '0;
        if (!buf_full) exp_udr++;
        buf_full = 1'b0;
        ss = 1'b0;
        repeat (6) @(negedge clk);
        check("busy_start", {31'h0, busy}, 32'h1);
        check("tx_ready_start", {31'h0, tx_ready}, {31'h0, !buf_full});
    endtask

    task automatic send_bit(input logic b, input int half, output logic m);
        mosi = b;
        sclk = 1'b1;
        repeat (half) @(negedge clk);
        m    = miso;
        sclk = 1'b0;
        repeat (half) @(negedge clk);
    endtask

    task automatic end_frame();
        repeat (4) @(negedge clk);
        ss   = 1'b1;
        mosi = 1'b0;
        repeat (6) @(negedge clk);
        check("busy_end", {31'h0, busy}, 32'h0);
    endtask

    task automatic full_frame(input logic [DW-1:0] w, input int half, input int nbits);
        logic [DW-1:0] em;
        logic [DW-1:0] got;
        logic          m;
        got = '0;
        if (nbits == DW) begin
            rx_exp_q.push_back(w);
            exp_rx++;
            last_rx = w;
        end else begin
            exp_err++;
        end
        start_frame(em);
        for (int i = 0; i < nbits; i++) begin
            send_bit(w[DW-1-i], half, m);
            got[DW-1-i] = m;
        end
        end_frame();
        check("rx_valid_cnt", mon_rx, exp_rx);
        check("frame_err_cnt", mon_err, exp_err);
        check("underrun_cnt", mon_udr, exp_udr);
        if (nbits == DW)
            check("miso_word", {16'h0, got}, {16'h0, em});
        else
            check("rx_data_hold", {16'h0, rx_data}, {16'h0, last_rx});
        $display("[TB] frame mosi=%04h bits=%0d half=%0d miso=%04h expect_miso=%04h",
                 w, nbits, half, got, em);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] em;
        logic          m;
        rst = 1'b1; sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
        tx_data = '0; tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", {31'h0, miso}, 32'h0);
        check("rst_tx_ready", {31'h0, tx_ready}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("rst_rx_data", {16'h0, rx_data}, 32'h0);
        check("rst_frame_err", {31'h0, frame_err}, 32'h0);
        check("rst_underrun", {31'h0, tx_underrun}, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic frame
        tb_write(16'hA55A);
        full_frame(16'h1234, 2, DW);

        // Back-to-back, second tx word written mid-frame
        tb_write(16'h0001);
        fork
            full_frame(16'hFFFF, 2, DW);
            begin
                repeat (30) @(negedge clk);
                tb_write(16'h8000);
            end
        join
        full_frame(16'h0000, 2, DW);

        // Underrun
        full_frame(16'($urandom), 2, DW);

        // Early ss deassert after 9 bits
        tb_write(16'($urandom));
        full_frame(16'($urandom), 2, 9);

        // Reset in the middle of a frame
        tb_write(16'h5A5A);
        start_frame(em);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 2, m);
        rst = 1'b1;
        #1;
        check("rstmid_miso", {31'h0, miso}, 32'h0);
        check("rstmid_tx_ready", {31'h0, tx_ready}, 32'h1);
        check("rstmid_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        ss = 1'b1;
        mosi = 1'b0;
        buf_full = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        $display("[TB] reset applied mid-frame after 5 bits");
        tb_write(16'($urandom));
        full_frame(16'hC3C3, 2, DW);

        // sclk activity with ss high must be ignored, then a slow frame
        for (int k = 0; k < 8; k++) begin
            sclk = 1'b1;
            repeat (10) @(negedge clk);
            sclk = 1'b0;
            repeat (10) @(negedge clk);
        end
        check("idle_sclk_busy", {31'h0, busy}, 32'h0);
        check("idle_sclk_rx_cnt", mon_rx, exp_rx);
        check("idle_sclk_err_cnt", mon_err, exp_err);
        $display("[TB] sclk toggled 8 times with ss deasserted");
        tb_write(16'($urandom));
        full_frame(16'($urandom), 10, DW);

        // Randomized frames
        for (int r = 0; r < 12; r++) begin
            int half;
            int nbits;
            half  = int'($urandom_range(2, 5));
            nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DW-1)) : DW;
            if ($urandom_range(0, 1) == 1) tb_write(16'($urandom));
            full_frame(16'($urandom), half, nbits);
        end

        check("rx_queue_empty", rx_exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder that pairs with the team's SPI master on the same board or FPGA.
- Runs on the system clock and oversamples the `sclk`, `ss` and `mosi` pins through synchronizers.
- Receives one `DATA_WIDTH`-bit MSB-first frame per `ss` assertion and returns a word from a one-entry transmit buffer on `miso`.
- Presents received words to local logic as a one-cycle valid pulse.

Parameters:
- `DATA_WIDTH`, 16: frame length in bits; the shift registers and data ports use this width.
- `SYNC_STAGES`, 2: flop stages on each of `sclk`, `ss` and `mosi`; must be ≥2.

Ports:
- `clk`  in  1  system clock; every flop in the block uses it.
- `rst`  in  1  asynchronous, active-high reset.
- `sclk`  in  1  SPI clock from the master; idles low (CPOL=0).
- `ss`  in  1  active-low slave select.
- `mosi`  in  1  serial data from the master.
- `miso`  out  1  serial data to the master; held 0 while not selected.
- `tx_data`  in  DATA_WIDTH  word to send in the next frame.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  the transmit buffer is empty.
- `rx_data`  out  DATA_WIDTH  last complete received frame.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` was updated.
- `busy`  out  1  a frame is in progress.
- `frame_err`  out  1  one-cycle pulse: `ss` deasserted before `DATA_WIDTH` bits were received.
- `tx_underrun`  out  1  one-cycle pulse: a frame started with the transmit buffer empty.

Behaviour:
- Reset values:
  - `miso`, `rx_valid`, `frame_err`, `tx_underrun`, `busy` = 0.
  - `rx_data` = 0.
  - `tx_ready` = 1.
  - Shift registers and bit counter = 0.
  - Synchronizer flops: `sclk` and `mosi` stages reset to 0, `ss` stages reset to 1.
  - FSM = IDLE.
- Synchronization and edge detection:
  - Each pin passes through `SYNC_STAGES` flops.
  - One further registered copy of synchronized `sclk` and `ss` provides edge detection.
  - An edge is therefore acted on `SYNC_STAGES`+1 clk cycles after the pin changes (3 at default).
  - `mosi` uses the same synchronizer depth as `sclk`, so the sampled `mosi` matches the detected edge.
- Protocol timing:
  - The master changes `mosi` on the `sclk` rising edge.
  - The slave samples `mosi` on the detected `sclk` falling edge.
  - The slave changes `miso` on the cycle after a detected falling edge; the master samples `miso` on its falling edge.
  - Supported `sclk`: each level stable for ≥2 clk cycles (period ≥4 clk).
- Transmit buffer:
  - `tx_ready` = 1 when the buffer is empty.
  - A word is accepted when `tx_valid` && `tx_ready`; `tx_ready` drops the next cycle.
  - The buffer empties when its word is loaded at frame start.
  - `tx_data` is ignored while `tx_ready` = 0.
- FSM states: IDLE, SHIFT, WAIT_SS.
- IDLE:
  - `miso` = 0, `busy` = 0.
  - On detected `ss` falling edge, go to SHIFT and `busy` = 1.
  - Load `tx_shift` from the buffer if it is full; otherwise load all-zeros and pulse `tx_underrun`.
  - Clear the bit counter.
  - `miso` = MSB of the loaded word on the next cycle.
- SHIFT:
  - Rising edges are ignored.
  - On each detected falling edge:
    - `rx_shift` = {`rx_shift`[DATA_WIDTH-2:0], `mosi_sync`}.
    - Counter +1.
    - `tx_shift` shifts left one place; `miso` = new MSB.
  - When the counter reaches `DATA_WIDTH` on a falling edge:
    - `rx_data` = the completed shift value, including the bit just sampled.
    - `rx_valid` = 1 for exactly one cycle.
    - Go to WAIT_SS.
- WAIT_SS:
  - `miso` = 0; `sclk` edges are ignored.
  - On detected `ss` rising edge, go to IDLE and `busy` = 0.
- Early `ss` rise in SHIFT:
  - Abort the frame and go to IDLE.
  - Pulse `frame_err`; no `rx_valid`; `rx_data` is unchanged.
  - The loaded tx word is discarded and is not re-buffered.
- Simultaneous events:
  - If an `ss` falling edge and a buffer write occur in the same cycle, the frame loads the old buffer state (underrun if it was empty), and the new word is accepted for the next frame.
  - `sclk` edges seen while `ss_sync` = 1 are ignored in every state.
- Reset during a frame:
  - All state clears immediately; the buffered tx word is lost.
  - After reset, the next `ss` falling edge starts a clean frame.
- Counter width: $clog2(DATA_WIDTH+1) bits; no wrap-around is possible because the FSM leaves SHIFT at `DATA_WIDTH`.

Decomposition:
- Shared package `spi_pkg`:
  - FSM state enum (IDLE/SHIFT/WAIT_SS).
  - Default `DATA_WIDTH` constant (16), shared with the SPI master.
- Sub-module `spi_sync_edge`:
  - Parameterized `SYNC_STAGES` synchronizer on one bit with a configurable reset value.
  - Outputs: `sync`, `rise`, `fall`.
  - Instantiated for `sclk` and `ss`; `mosi` uses it with its edge outputs unused.

Test Plan:
- Basic frame, `sclk` period 4 clk:
  - Stimulus: buffer `tx_data`=16'hA55A, then master sends 16'h1234.
  - Response: `rx_valid` pulses once with `rx_data`=16'h1234; master receives 16'hA55A; `tx_ready` returns to 1 after `ss` falls.
- Back-to-back frames, second word written during frame 1:
  - Stimulus: frame 1 sends 16'hFFFF with tx 16'h0001; tx 16'h8000 is written mid-frame 1; frame 2 sends 16'h0000.
  - Response: frame 2 returns 16'h8000 and `rx_data`=16'h0000; no `tx_underrun` on either frame.
- Underrun:
  - Stimulus: no tx word is written before `ss` falls.
  - Response: `tx_underrun` pulses 1 cycle; `miso` = 0 for all 16 bits; the received word is still captured correctly.
- Early `ss` deassert:
  - Stimulus: `ss` rises after 9 falling edges.
  - Response: `frame_err` pulses 1 cycle; no `rx_valid`; `rx_data` keeps its prior value; `busy` = 0.
- Reset mid-frame:
  - Stimulus: assert `rst` after 5 bits.
  - Response: `miso`=0, `tx_ready`=1, `busy`=0 immediately; the following full frame of 16'hC3C3 is received exactly.
- Slow `sclk` / long holds:
  - Stimulus: `sclk` phase 10 clk; `sclk` glitch-free toggling while `ss`=1.
  - Response: no `rx_valid`, `frame_err` or FSM change while `ss`=1; the frame completes normally when `ss` later falls.
